// File: rtl/conv2d_output_serializer_pkg.sv
// Shared conv2d types: output channel count, channel index width and the per-pixel vector type.
// Imported by conv2d_vec_fifo and conv2d_output_serializer.
package conv2d_output_serializer_pkg;

    localparam int NUM_OUT_CHANNELS = 4;
    localparam int CH_IDX_W = (NUM_OUT_CHANNELS > 1) ? $clog2(NUM_OUT_CHANNELS) : 1;

    // Channel i occupies byte [i]; the same layout is produced by conv2d_activation.
    typedef logic [NUM_OUT_CHANNELS-1:0][7:0] conv2d_px_vec_t;

    function automatic logic [CH_IDX_W-1:0] last_chan_idx();
        return CH_IDX_W'(NUM_OUT_CHANNELS - 1);
    endfunction

endpackage

// File: rtl/conv2d_vec_fifo.sv
// Small FIFO of whole pixel vectors for the conv2d output serializer.
// Push and pop may coincide while full; the pointers wrap modulo DEPTH.
module conv2d_vec_fifo
    import conv2d_output_serializer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  conv2d_px_vec_t           push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output conv2d_px_vec_t           head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    conv2d_px_vec_t     mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    // Storage carries no reset; the head is masked downstream while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/conv2d_output_serializer.sv
// Buffers activated pixel vectors and streams them out one channel byte per valid/ready beat.
// Define CONV2D_SER_LAST_EN to add the frame pixel counter and the out_last port.
module conv2d_output_serializer
    import conv2d_output_serializer_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int FRAME_PIXELS = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  conv2d_px_vec_t                 in_px_vec,
    input  logic                           in_valid,
    output logic [7:0]                     out_data,
    output logic [CH_IDX_W-1:0]            out_chan,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
`ifdef CONV2D_SER_LAST_EN
    output logic                           out_last,
`endif
    output logic                           overflow
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FRAME_PIXELS < 1) begin : g_bad_cfg
        $error("conv2d_output_serializer: FIFO_DEPTH must be a power of 2 >= 2 and FRAME_PIXELS >= 1");
    end

    logic                   full;
    logic                   empty;
    logic                   beat;
    logic                   last_ch;
    logic                   pop;
    logic                   push;
    logic [CH_IDX_W-1:0]    ch_idx;
    conv2d_px_vec_t         head;

    assign out_valid = !empty;
    assign beat      = out_valid && out_ready;
    assign last_ch   = (ch_idx == last_chan_idx());
    assign pop       = beat && last_ch;
    // A same-cycle pop frees the slot, so a full FIFO can still take the incoming vector.
    assign push      = in_valid && (!full || pop);

    conv2d_vec_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_px_vec),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level),
        .head      (head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_idx   <= '0;
            overflow <= 1'b0;
        end else begin
            if (beat) begin
                ch_idx <= last_ch ? '0 : ch_idx + 1'b1;
            end
            if (in_valid && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign out_data = empty ? 8'h00 : head[ch_idx];
    assign out_chan = empty ? '0 : ch_idx;

`ifdef CONV2D_SER_LAST_EN
    localparam int PIX_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;

    logic [PIX_W-1:0] pix_cnt;
    logic             frame_end;

    assign frame_end = (pix_cnt == PIX_W'(FRAME_PIXELS - 1));

    // Counts popped vectors so the final beat of each frame can be tagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt <= '0;
        end else if (pop) begin
            pix_cnt <= frame_end ? '0 : pix_cnt + 1'b1;
        end
    end

    assign out_last = out_valid && last_ch && frame_end;
`endif

endmodule

// File: tb/tb_conv2d_output_serializer.sv
// Directed self-checking bench for conv2d_output_serializer (4 channels, depth 4, 2-pixel frames).
// Build with CONV2D_SER_LAST_EN defined to also exercise out_last.
module tb_conv2d_output_serializer;
    import conv2d_output_serializer_pkg::*;

    logic                  clk;
    logic                  rst;
    conv2d_px_vec_t        in_px_vec;
    logic                  in_valid;
    logic [7:0]            out_data;
    logic [CH_IDX_W-1:0]   out_chan;
    logic                  out_valid;
    logic                  out_ready;
    logic [2:0]            fifo_level;
    logic                  overflow;
`ifdef CONV2D_SER_LAST_EN
    logic                  out_last;
`endif

    int checks = 0;
    int errors = 0;

    conv2d_output_serializer #(
        .FIFO_DEPTH   (4),
        .FRAME_PIXELS (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_px_vec  (in_px_vec),
        .in_valid   (in_valid),
        .out_data   (out_data),
        .out_chan   (out_chan),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
`ifdef CONV2D_SER_LAST_EN
        .out_last   (out_last),
`endif
        .overflow   (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic conv2d_px_vec_t mkVec(input logic [7:0] base);
        conv2d_px_vec_t v;
        for (int c = 0; c < NUM_OUT_CHANNELS; c++) begin
            v[c] = base + 8'(c);
        end
        return v;
    endfunction

    task automatic applyStimulus(input conv2d_px_vec_t v);
        in_px_vec = v;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic drainVec(input string tag, input conv2d_px_vec_t v);
        out_ready = 1'b1;
        for (int c = 0; c < NUM_OUT_CHANNELS; c++) begin
            checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, "_data"}, 32'(out_data), 32'(v[c]));
            checkOutput({tag, "_chan"}, 32'(out_chan), 32'(c));
            @(negedge clk);
        end
    endtask

    task automatic resetDut();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    conv2d_px_vec_t vecs [5];
    conv2d_px_vec_t vecE;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_px_vec = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_level", 32'(fifo_level), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_data", 32'(out_data), 32'd0);
        checkOutput("rst_chan", 32'(out_chan), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single pass");
        out_ready = 1'b1;
        applyStimulus({8'h04, 8'h03, 8'h02, 8'h01});
        for (int c = 0; c < 4; c++) begin
            checkOutput("t1_valid", 32'(out_valid), 32'd1);
            checkOutput("t1_data", 32'(out_data), 32'(c + 1));
            checkOutput("t1_chan", 32'(out_chan), 32'(c));
            @(negedge clk);
        end
        checkOutput("t1_done_valid", 32'(out_valid), 32'd0);
        checkOutput("t1_done_level", 32'(fifo_level), 32'd0);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(mkVec(8'h11));
        for (int i = 0; i < 5; i++) begin
            checkOutput("t2_hold_data", 32'(out_data), 32'h11);
            checkOutput("t2_hold_chan", 32'(out_chan), 32'd0);
            checkOutput("t2_hold_level", 32'(fifo_level), 32'd1);
            @(negedge clk);
        end
        drainVec("t2_drain", mkVec(8'h11));
        checkOutput("t2_empty", 32'(out_valid), 32'd0);

        $display("[TB] overflow");
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            vecs[k] = mkVec(8'(8'h20 + 8'(k * 16)));
            applyStimulus(vecs[k]);
        end
        checkOutput("t3_level", 32'(fifo_level), 32'd4);
        checkOutput("t3_overflow", 32'(overflow), 32'd1);
        for (int k = 0; k < 4; k++) begin
            drainVec("t3_drain", vecs[k]);
        end
        checkOutput("t3_empty", 32'(out_valid), 32'd0);
        checkOutput("t3_sticky", 32'(overflow), 32'd1);

        $display("[TB] reset mid-stream");
        out_ready = 1'b1;
        applyStimulus(mkVec(8'h60));
        @(negedge clk);
        checkOutput("t5_beat2_chan", 32'(out_chan), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("t5_rst_level", 32'(fifo_level), 32'd0);
        checkOutput("t5_rst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(mkVec(8'h70));
        drainVec("t5_restart", mkVec(8'h70));

        $display("[TB] full with same-cycle push/pop");
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vecs[k] = mkVec(8'(8'h80 + 8'(k * 8)));
            applyStimulus(vecs[k]);
        end
        checkOutput("t4_full_level", 32'(fifo_level), 32'd4);
        vecE = mkVec(8'hA0);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            checkOutput("t4_head_data", 32'(out_data), 32'(vecs[0][c]));
            if (c == 3) begin
                in_px_vec = vecE;
                in_valid  = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checkOutput("t4_level_kept", 32'(fifo_level), 32'd4);
        checkOutput("t4_no_overflow", 32'(overflow), 32'd0);
        for (int k = 1; k < 4; k++) begin
            drainVec("t4_drain", vecs[k]);
        end
        drainVec("t4_new_vec", vecE);
        checkOutput("t4_empty", 32'(out_valid), 32'd0);

`ifdef CONV2D_SER_LAST_EN
        $display("[TB] frame last");
        resetDut();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(mkVec(8'(8'h10 * (k + 1))));
        end
        out_ready = 1'b1;
        for (int b = 0; b < 12; b++) begin
            checkOutput("t6_last", 32'(out_last), (b == 7) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        checkOutput("t6_empty", 32'(out_valid), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
